aemb2_fsl_slave: RTL

//  Responder end of the AEMB2 FSL (cwb) bus: services core PUT/GET issued on cwb_* by the ALU stage.

---
 rtl/aemb2_fsl_pkg.sv | 30 +++
 rtl/aemb2_fsl_fifo.sv | 68 ++++++
 rtl/aemb2_fsl_slave.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/aemb2_fsl_pkg.sv
// Shared definitions for the AEMB2 FSL responder: cwb field positions, access kinds
// and the registered core response.
package aemb2_fsl_pkg;

   localparam int          TGA_N   = 1;      // non-blocking flag
   localparam int          TGA_C   = 0;      // control-word flag
   localparam logic [3:0]  SEL_FSL = 4'hF;
   localparam int          CHW     = 5;      // channel field width
   localparam int          MAXCH   = 32;
   localparam int          DW      = 32;
   localparam int          FW      = DW + 1; // FIFO word: {ctl, data}

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_PUT,
      ACC_GET,
      ACC_BAD
   } acc_e;

   typedef struct packed {
      logic          ack;
      logic          err;
      logic [DW-1:0] dat;
   } rsp_t;

   function automatic logic [FW-1:0] fsl_word(input logic ctl, input logic [DW-1:0] dat);
      return {ctl, dat};
   endfunction

endpackage

// File: rtl/aemb2_fsl_fifo.sv
// First-word-fall-through FIFO with synchronous reset; full/empty come from the
// registered count, so push and pop never see each other's effect within a cycle.
module aemb2_fsl_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] dat_i,
   output logic [W-1:0] dat_o,
   output logic         full_o,
   output logic         empty_o,
   output logic [AW:0]  count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dat_o   = mem_q[rptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[wptr_q] = dat_i;
         wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop)
         rptr_d = rptr_q + AW'(1);
      if (do_push && !do_pop)
         cnt_d = cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop)
         cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only observable once counted.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/aemb2_fsl_slave.sv
// AEMB2 FSL responder: decodes core PUT/GET on cwb, steers them to per-channel TX/RX
// FIFOs and registers the ack/err/data response.
module aemb2_fsl_slave
   import aemb2_fsl_pkg::*;
#(
   parameter int CHN   = 2,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cwb_stb_i,
   input  logic              cwb_we_i,
   input  logic [6:2]        cwb_adr_i,
   input  logic [1:0]        cwb_tga_i,
   input  logic [3:0]        cwb_sel_i,
   input  logic [31:0]       cwb_dat_i,
   output logic [31:0]       cwb_dat_o,
   output logic              cwb_ack_o,
   output logic              cwb_err_o,
   output logic [32*CHN-1:0] fsl_m_dat_o,
   output logic [CHN-1:0]    fsl_m_ctl_o,
   output logic [CHN-1:0]    fsl_m_vld_o,
   input  logic [CHN-1:0]    fsl_m_rdy_i,
   input  logic [32*CHN-1:0] fsl_s_dat_i,
   input  logic [CHN-1:0]    fsl_s_ctl_i,
   input  logic [CHN-1:0]    fsl_s_vld_i,
   output logic [CHN-1:0]    fsl_s_rdy_o
);

   rsp_t                      rsp_q, rsp_d;
   acc_e                      acc;
   logic                      req, bad, nblk, ctl;
   logic [CHW-1:0]            ch;
   logic                      do_push, do_pop;

   // Sized to the full channel space so the 5-bit channel can index directly;
   // unimplemented slots read as full/empty and are never selected anyway.
   logic [MAXCH-1:0]          tx_full;
   logic [MAXCH-1:0]          rx_empty;
   logic [MAXCH-1:0][FW-1:0]  rx_head;

   assign cwb_ack_o = rsp_q.ack;
   assign cwb_err_o = rsp_q.err;
   assign cwb_dat_o = rsp_q.dat;

   assign ch   = cwb_adr_i;
   assign nblk = cwb_tga_i[TGA_N];
   assign ctl  = cwb_tga_i[TGA_C];
   assign bad  = (int'(ch) >= CHN);
   // Masking with ack keeps a held strobe from being serviced twice.
   assign req  = cwb_stb_i & (cwb_sel_i == SEL_FSL) & ~rsp_q.ack;

   always_comb begin
      acc = ACC_IDLE;
      if (req) begin
         if (bad)           acc = ACC_BAD;
         else if (cwb_we_i) acc = ACC_PUT;
         else               acc = ACC_GET;
      end
   end

   always_comb begin
      rsp_d     = '0;
      rsp_d.dat = rsp_q.dat;
      do_push   = 1'b0;
      do_pop    = 1'b0;
      case (acc)
         ACC_PUT: begin
            if (!tx_full[ch]) begin
               do_push   = 1'b1;
               rsp_d.ack = 1'b1;
            end else if (nblk) begin
               rsp_d.ack = 1'b1;
               rsp_d.err = 1'b1;
            end
         end
         ACC_GET: begin
            if (!rx_empty[ch]) begin
               do_pop    = 1'b1;
               rsp_d.ack = 1'b1;
               rsp_d.dat = rx_head[ch][DW-1:0];
               rsp_d.err = (rx_head[ch][DW] != ctl);
            end else if (nblk) begin
               rsp_d.ack = 1'b1;
               rsp_d.err = 1'b1;
               rsp_d.dat = '0;
            end
         end
         ACC_BAD: begin
            rsp_d.ack = 1'b1;
            rsp_d.err = 1'b1;
            rsp_d.dat = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) rsp_q <= '0;
      else       rsp_q <= rsp_d;
   end

   for (genvar k = 0; k < MAXCH; k++) begin : g_ch
      if (k < CHN) begin : g_on
         logic [FW-1:0] tx_head;
         logic          tx_empty, rx_full;
         logic [AW:0]   tx_cnt, rx_cnt;
         logic          unused_cnt;

         assign unused_cnt = ^{tx_cnt, rx_cnt};

         aemb2_fsl_fifo #(.W(FW), .DEPTH(DEPTH), .AW(AW)) u_tx (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (do_push & (ch == CHW'(k))),
            .pop_i   (fsl_m_rdy_i[k]),
            .dat_i   (fsl_word(ctl, cwb_dat_i)),
            .dat_o   (tx_head),
            .full_o  (tx_full[k]),
            .empty_o (tx_empty),
            .count_o (tx_cnt)
         );

         aemb2_fsl_fifo #(.W(FW), .DEPTH(DEPTH), .AW(AW)) u_rx (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (fsl_s_vld_i[k]),
            .pop_i   (do_pop & (ch == CHW'(k))),
            .dat_i   (fsl_word(fsl_s_ctl_i[k], fsl_s_dat_i[32*k +: 32])),
            .dat_o   (rx_head[k]),
            .full_o  (rx_full),
            .empty_o (rx_empty[k]),
            .count_o (rx_cnt)
         );

         assign fsl_m_dat_o[32*k +: 32] = tx_head[DW-1:0];
         assign fsl_m_ctl_o[k]          = tx_head[DW];
         assign fsl_m_vld_o[k]          = ~tx_empty;
         assign fsl_s_rdy_o[k]          = ~rx_full;
      end else begin : g_off
         assign tx_full[k]  = 1'b1;
         assign rx_empty[k] = 1'b1;
         assign rx_head[k]  = '0;
      end
   end

endmodule
